// File: rtl/ysyx_040066_mem_arbiter.sv
// Two-master (IF, LSU) to one memory port arbiter. LSU wins by default; a starvation counter forces IF through.
// Optional WAIT timeout is enabled with `define YSYX_040066_ARB_TIMEOUT_EN.
module ysyx_040066_mem_arbiter #(
    parameter int AW           = 64,
    parameter int DW           = 64,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [AW-1:0]   if_addr,
    output logic            if_ready,
    output logic            if_rsp_valid,
    input  logic            lsu_valid,
    input  logic [AW-1:0]   lsu_addr,
    input  logic            lsu_wr,
    input  logic [DW-1:0]   lsu_wdata,
    input  logic [DW/8-1:0] lsu_wmask,
    output logic            lsu_ready,
    output logic            lsu_rsp_valid,
    output logic [DW-1:0]   rsp_rdata,
    output logic            rsp_error,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_wr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wmask,
    input  logic            mem_rsp_valid,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_error
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t            state_q;
    logic              owner_lsu_q;
    logic [3:0]        starve_q, starve_d;
    logic [AW-1:0]     addr_q;
    logic              wr_q;
    logic [DW-1:0]     wdata_q;
    logic [DW/8-1:0]   wmask_q;
    logic              req_valid_q;
    logic              if_rsp_q, lsu_rsp_q;
    logic [DW-1:0]     rdata_q;
    logic              error_q;

`ifdef YSYX_040066_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0]     tmo_q;
`endif

    logic starved, grant_if, grant_lsu;

    // Once LSU has won STARVE_LIMIT times in a row over a waiting IF, IF takes the next slot.
    assign starved   = (starve_q == STARVE_MAX);
    assign grant_if  = (state_q == IDLE) && if_valid && (starved || !lsu_valid);
    assign grant_lsu = (state_q == IDLE) && lsu_valid && !(starved && if_valid);

    always_comb begin
        starve_d = starve_q;
        if (grant_if) begin
            starve_d = '0;
        end else if (grant_lsu && if_valid && !starved) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_lsu_q <= 1'b0;
            starve_q    <= '0;
            addr_q      <= '0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            req_valid_q <= 1'b0;
            if_rsp_q    <= 1'b0;
            lsu_rsp_q   <= 1'b0;
            rdata_q     <= '0;
            error_q     <= 1'b0;
`ifdef YSYX_040066_ARB_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            starve_q  <= starve_d;
            if_rsp_q  <= 1'b0;
            lsu_rsp_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_lsu) begin
                        owner_lsu_q <= 1'b1;
                        addr_q      <= lsu_addr;
                        wr_q        <= lsu_wr;
                        wdata_q     <= lsu_wdata;
                        wmask_q     <= lsu_wmask;
                        req_valid_q <= 1'b1;
                        state_q     <= REQ;
                    end else if (grant_if) begin
                        owner_lsu_q <= 1'b0;
                        addr_q      <= if_addr;
                        wr_q        <= 1'b0;
                        wdata_q     <= '0;
                        wmask_q     <= '0;
                        req_valid_q <= 1'b1;
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        req_valid_q <= 1'b0;
                        state_q     <= WAIT;
`ifdef YSYX_040066_ARB_TIMEOUT_EN
                        tmo_q       <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        rdata_q   <= mem_rdata;
                        error_q   <= mem_error;
                        lsu_rsp_q <= owner_lsu_q;
                        if_rsp_q  <= !owner_lsu_q;
                        state_q   <= RESP;
                    end
`ifdef YSYX_040066_ARB_TIMEOUT_EN
                    // Give up after TIMEOUT WAIT cycles and report an error to the owner.
                    else if (tmo_q == TMO_LAST) begin
                        rdata_q   <= '0;
                        error_q   <= 1'b1;
                        lsu_rsp_q <= owner_lsu_q;
                        if_rsp_q  <= !owner_lsu_q;
                        state_q   <= RESP;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign if_ready      = grant_if;
    assign lsu_ready     = grant_lsu;
    assign if_rsp_valid  = if_rsp_q;
    assign lsu_rsp_valid = lsu_rsp_q;
    assign rsp_rdata     = rdata_q;
    assign rsp_error     = error_q;
    assign mem_req_valid = req_valid_q;
    assign mem_addr      = addr_q;
    assign mem_wr        = wr_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;

endmodule

// File: tb/tb_ysyx_040066_mem_arbiter.sv
// Scoreboard bench for ysyx_040066_mem_arbiter with a small behavioural memory.
// The timeout scenario is built when YSYX_040066_ARB_TIMEOUT_EN is defined.
module tb_ysyx_040066_mem_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
`ifdef YSYX_040066_ARB_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif
    localparam logic [63:0] ERR_ADDR = 64'h0000_0000_0200_1000;

    logic            clk = 1'b0;
    logic            rst;
    logic            if_valid, lsu_valid, lsu_wr;
    logic [AW-1:0]   if_addr, lsu_addr;
    logic [DW-1:0]   lsu_wdata;
    logic [DW/8-1:0] lsu_wmask;
    logic            if_ready, if_rsp_valid, lsu_ready, lsu_rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_error;
    logic            mem_req_valid, mem_req_ready, mem_wr, mem_rsp_valid, mem_error;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata, mem_rdata;
    logic [DW/8-1:0] mem_wmask;

    ysyx_040066_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_addr(if_addr), .if_ready(if_ready), .if_rsp_valid(if_rsp_valid),
        .lsu_valid(lsu_valid), .lsu_addr(lsu_addr), .lsu_wr(lsu_wr), .lsu_wdata(lsu_wdata),
        .lsu_wmask(lsu_wmask), .lsu_ready(lsu_ready), .lsu_rsp_valid(lsu_rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .mem_error(mem_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        lsu;
        logic [63:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    int   stall_cycles = 0;
    int   rsp_delay = 0;
    bit   drop_rsp = 1'b0;

    function automatic logic [63:0] mem_data(input logic [63:0] a);
        return (a == 64'h8000_0000) ? 64'h13 : (a ^ 64'h0000_5A5A_0000_0000);
    endfunction

    function automatic void push_exp(input logic lsu, input logic [63:0] data, input logic err);
        exp_t e;
        e.lsu  = lsu;
        e.data = data;
        e.err  = err;
        sb.push_back(e);
    endfunction

    // Behavioural memory: stalls ready, then answers rsp_delay cycles after acceptance.
    initial begin
        logic [63:0] pend_addr;
        bit          pend;
        int          pend_wait;
        int          stall_cnt;
        pend = 1'b0; pend_wait = 0; stall_cnt = 0; pend_addr = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0; mem_error = 1'b0;
        forever begin
            @(posedge clk); #1;
            mem_rsp_valid = 1'b0;
            if (mem_req_ready) begin
                mem_req_ready = 1'b0;
                pend      = !drop_rsp;
                pend_wait = rsp_delay;
            end
            if (pend) begin
                if (pend_wait == 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rdata     = mem_data(pend_addr);
                    mem_error     = (pend_addr == ERR_ADDR);
                    pend          = 1'b0;
                end else begin
                    pend_wait--;
                end
            end
            if (mem_req_valid && !mem_req_ready && !pend && !rst) begin
                if (stall_cnt < stall_cycles) begin
                    stall_cnt++;
                end else begin
                    stall_cnt     = 0;
                    mem_req_ready = 1'b1;
                    pend_addr     = mem_addr;
                end
            end
        end
    end

    // Scoreboard: every response pulse pops the oldest expectation.
    always @(negedge clk) begin
        if (if_rsp_valid || lsu_rsp_valid) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_rsp: if_rsp=%b lsu_rsp=%b, required no response", if_rsp_valid, lsu_rsp_valid);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({lsu_rsp_valid, if_rsp_valid, rsp_rdata, rsp_error} !== {e.lsu, !e.lsu, e.data, e.err}) begin
                    miscompares++;
                    $display("[TB] FAIL rsp: got lsu=%b if=%b data=%h err=%b, required lsu=%b if=%b data=%h err=%b",
                             lsu_rsp_valid, if_rsp_valid, rsp_rdata, rsp_error, e.lsu, !e.lsu, e.data, e.err);
                end
            end
        end
    end

    task automatic wait_grant(input bit want_lsu, output int cycles);
        cycles = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (want_lsu ? lsu_ready : if_ready) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL %s_drain: %0d responses outstanding, required 0", name, sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({if_ready, lsu_ready, if_rsp_valid, lsu_rsp_valid, mem_req_valid, mem_wr, rsp_error} !== 7'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl: got %b, required 0000000",
                     {if_ready, lsu_ready, if_rsp_valid, lsu_rsp_valid, mem_req_valid, mem_wr, rsp_error});
        end
        vectors++;
        if ({mem_addr, mem_wdata, mem_wmask, rsp_rdata} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_data: addr=%h wdata=%h wmask=%h rdata=%h, required all 0",
                     mem_addr, mem_wdata, mem_wmask, rsp_rdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_if_read();
        int lat;
        bit seen;
        push_exp(1'b0, 64'h13, 1'b0);
        if_valid = 1'b1; if_addr = 64'h8000_0000;
        @(negedge clk);
        vectors++;
        if (if_ready !== 1'b1 || lsu_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL if_grant: if_ready=%b lsu_ready=%b, required 1 0", if_ready, lsu_ready);
        end
        @(posedge clk); #1;
        if_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if ({mem_req_valid, mem_addr, mem_wr, mem_wmask} !== {1'b1, 64'h8000_0000, 1'b0, 8'h00}) begin
            miscompares++;
            $display("[TB] FAIL if_req: valid=%b addr=%h wr=%b wmask=%h, required 1 80000000 0 00",
                     mem_req_valid, mem_addr, mem_wr, mem_wmask);
        end
        lat = 1; seen = 1'b0;
        while (lat < 12 && !seen) begin
            @(negedge clk);
            lat++;
            seen = if_rsp_valid;
        end
        vectors++;
        if (lat != 3 || !seen) begin
            miscompares++;
            $display("[TB] FAIL if_latency: got %0d (seen=%b), required 3", lat, seen);
        end
        @(negedge clk);
        vectors++;
        if (if_rsp_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL if_pulse_width: if_rsp_valid=%b, required 0", if_rsp_valid);
        end
        wait_drain("if_read");
    endtask

    task automatic test_priority();
        int cyc;
        push_exp(1'b1, mem_data(64'h0200_bff8), 1'b0);
        push_exp(1'b0, 64'h13, 1'b0);
        if_valid  = 1'b1; if_addr = 64'h8000_0000;
        lsu_valid = 1'b1; lsu_addr = 64'h0200_bff8; lsu_wr = 1'b1; lsu_wdata = 64'h55; lsu_wmask = 8'hFF;
        @(negedge clk);
        vectors++;
        if (lsu_ready !== 1'b1 || if_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL prio_grant: lsu_ready=%b if_ready=%b, required 1 0", lsu_ready, if_ready);
        end
        @(posedge clk); #1;
        lsu_valid = 1'b0; lsu_wr = 1'b0;
        @(negedge clk);
        vectors++;
        if ({mem_req_valid, mem_addr, mem_wr, mem_wdata, mem_wmask, if_ready} !==
            {1'b1, 64'h0200_bff8, 1'b1, 64'h55, 8'hFF, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL prio_req: valid=%b addr=%h wr=%b wdata=%h wmask=%h if_ready=%b, required 1 0200bff8 1 55 ff 0",
                     mem_req_valid, mem_addr, mem_wr, mem_wdata, mem_wmask, if_ready);
        end
        wait_grant(1'b0, cyc);
        vectors++;
        if (cyc != 2) begin
            miscompares++;
            $display("[TB] FAIL prio_if_next: IF granted after %0d more cycles, required 2", cyc);
        end
        @(posedge clk); #1;
        if_valid = 1'b0;
        wait_drain("priority");
    endtask

    task automatic test_starve();
        int cyc;
        bit exp_lsu;
        for (int g = 0; g < 10; g++) begin
            exp_lsu = (g % 5) != 4;
            push_exp(exp_lsu, exp_lsu ? mem_data(64'h8000_1000) : 64'h13, 1'b0);
        end
        if_valid  = 1'b1; if_addr = 64'h8000_0000;
        lsu_valid = 1'b1; lsu_addr = 64'h8000_1000; lsu_wr = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
        for (int g = 0; g < 10; g++) begin
            exp_lsu = (g % 5) != 4;
            cyc = -1;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (if_ready || lsu_ready) begin
                    cyc = i;
                    break;
                end
            end
            vectors++;
            if (cyc < 0 || lsu_ready !== exp_lsu || if_ready !== !exp_lsu) begin
                miscompares++;
                $display("[TB] FAIL starve_grant%0d: lsu_ready=%b if_ready=%b wait=%0d, required %b %b",
                         g, lsu_ready, if_ready, cyc, exp_lsu, !exp_lsu);
            end
            @(posedge clk);
        end
        #1;
        if_valid = 1'b0; lsu_valid = 1'b0;
        wait_drain("starve");
    endtask

    task automatic test_stall();
        int cyc;
        stall_cycles = 5;
        push_exp(1'b1, mem_data(64'h8000_0040), 1'b0);
        lsu_valid = 1'b1; lsu_addr = 64'h8000_0040; lsu_wr = 1'b1; lsu_wdata = 64'hDEAD_BEEF; lsu_wmask = 8'h0F;
        wait_grant(1'b1, cyc);
        @(posedge clk); #1;
        lsu_valid = 1'b0; lsu_wr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if ({mem_req_valid, mem_addr, mem_wr, mem_wdata, mem_wmask, if_rsp_valid, lsu_rsp_valid} !==
                {1'b1, 64'h8000_0040, 1'b1, 64'hDEAD_BEEF, 8'h0F, 2'b00} || cyc < 0) begin
                miscompares++;
                $display("[TB] FAIL stall_hold%0d: valid=%b addr=%h wr=%b wdata=%h wmask=%h rsp=%b%b, required 1 80000040 1 deadbeef 0f 00",
                         i, mem_req_valid, mem_addr, mem_wr, mem_wdata, mem_wmask, if_rsp_valid, lsu_rsp_valid);
            end
        end
        stall_cycles = 0;
        wait_drain("stall");
    endtask

    task automatic test_error();
        int cyc;
        bit seen;
        push_exp(1'b1, mem_data(ERR_ADDR), 1'b1);
        lsu_valid = 1'b1; lsu_addr = ERR_ADDR; lsu_wr = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
        wait_grant(1'b1, cyc);
        @(posedge clk); #1;
        lsu_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = lsu_rsp_valid;
        end
        vectors++;
        if (!seen || rsp_error !== 1'b1 || if_rsp_valid !== 1'b0 || cyc < 0) begin
            miscompares++;
            $display("[TB] FAIL error_rsp: seen=%b rsp_error=%b if_rsp=%b, required 1 1 0", seen, rsp_error, if_rsp_valid);
        end
        wait_drain("error");
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit acc;
        rsp_delay = 1;
        lsu_valid = 1'b1; lsu_addr = 64'h8000_0080; lsu_wr = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
        wait_grant(1'b1, cyc);
        @(posedge clk); #1;
        lsu_valid = 1'b0;
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) begin
            @(negedge clk);
            acc = mem_req_valid && mem_req_ready;
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rsp_delay = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if ({if_rsp_valid, lsu_rsp_valid, mem_req_valid, rsp_error} !== 4'b0 ||
                rsp_rdata !== '0 || mem_addr !== '0 || !acc || cyc < 0) begin
                miscompares++;
                $display("[TB] FAIL reset_mid%0d: rsp=%b%b req=%b err=%b rdata=%h addr=%h acc=%b, required 0 0 0 0 0 0 1",
                         i, if_rsp_valid, lsu_rsp_valid, mem_req_valid, rsp_error, rsp_rdata, mem_addr, acc);
            end
        end
        @(posedge clk); #1;
    endtask

`ifdef YSYX_040066_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int cyc;
        int n;
        bit acc;
        bit seen;
        drop_rsp = 1'b1;
        push_exp(1'b1, 64'h0, 1'b1);
        lsu_valid = 1'b1; lsu_addr = 64'h8000_0100; lsu_wr = 1'b0;
        wait_grant(1'b1, cyc);
        @(posedge clk); #1;
        lsu_valid = 1'b0;
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) begin
            @(negedge clk);
            acc = mem_req_valid && mem_req_ready;
        end
        n = 0; seen = 1'b0;
        while (n < 40 && !seen) begin
            @(negedge clk);
            n++;
            seen = lsu_rsp_valid;
        end
        vectors++;
        if (!seen || n != TMO + 1 || rsp_error !== 1'b1 || !acc) begin
            miscompares++;
            $display("[TB] FAIL timeout: rsp after %0d cycles (seen=%b err=%b), required %0d with err 1",
                     n, seen, rsp_error, TMO + 1);
        end
        drop_rsp = 1'b0;
        wait_drain("timeout");
    endtask
`endif

    initial begin
        rst = 1'b1;
        if_valid = 1'b0; if_addr = '0;
        lsu_valid = 1'b0; lsu_addr = '0; lsu_wr = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
        test_reset();
        test_if_read();
        test_priority();
        test_starve();
        test_stall();
        test_error();
        test_reset_mid();
`ifdef YSYX_040066_ARB_TIMEOUT_EN
        test_timeout();
`endif
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
